// File: rtl/uart_cmd_decoder.sv
// Turns the UART receive byte stream into command pulses for the control unit.
// A line is one or two printable characters followed by CR or LF.
module uart_cmd_decoder #(
  parameter int unsigned P_BTN_PULSE_CYC = 100000,
  parameter int unsigned P_TIMEOUT_CYC   = 100000000
) (
  input  logic       iClk,
  input  logic       iRstn,
  input  logic [7:0] iRxData,
  input  logic       iRxValid,
  output logic       oBtnC,
  output logic       oBtnU,
  output logic       oBtnD,
  output logic       oBtnL,
  output logic       oBtnR,
  output logic       oTglSw0,
  output logic       oTglSw1,
  output logic       oTglSw2,
  output logic       oTglSw3,
  output logic       oClrSwTgl,
  output logic       oReqWatchRpt,
  output logic       oReqSr04Rpt,
  output logic       oReqTempRpt,
  output logic       oReqHumRpt,
  output logic       oCmdOk,
  output logic       oCmdErr
);

  localparam int unsigned BtnW = (P_BTN_PULSE_CYC > 1) ? $clog2(P_BTN_PULSE_CYC) : 1;
  localparam int unsigned ToW  = $clog2(P_TIMEOUT_CYC);
  localparam logic [BtnW-1:0] BtnLast = BtnW'(P_BTN_PULSE_CYC - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(P_TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StOne, StTwo, StDiscard} state_e;

  state_e          state_q, state_d;
  logic [7:0]      c0_q, c0_d;
  logic [7:0]      c1_q, c1_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;

  // Pending-execute stage: line contents latched at the terminator edge.
  logic            exec1_q, exec1_d;
  logic            exec2_q, exec2_d;
  logic            line_err_q, line_err_d;
  logic [7:0]      cmd0_q, cmd0_d;
  logic [7:0]      cmd1_q, cmd1_d;

  logic [4:0]      btn_q, btn_d;
  logic [BtnW-1:0] btn_cnt_q, btn_cnt_d;
  logic [3:0]      tgl_q, tgl_d;
  logic            clr_q, clr_d;
  logic [3:0]      req_q, req_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;

  logic       rx_evt;
  logic       is_term;
  logic       is_print;
  logic [7:0] rx_fold;

  always_comb begin
    rx_evt   = iRxValid && (iRxData != 8'h20);
    is_term  = (iRxData == 8'h0D) || (iRxData == 8'h0A);
    is_print = (iRxData >= 8'h21) && (iRxData <= 8'h7E);
    rx_fold  = ((iRxData >= 8'h61) && (iRxData <= 8'h7A)) ? (iRxData - 8'h20) : iRxData;
  end

  // Line FSM and mid-line timeout.
  always_comb begin
    state_d    = state_q;
    c0_d       = c0_q;
    c1_d       = c1_q;
    to_cnt_d   = to_cnt_q;
    exec1_d    = 1'b0;
    exec2_d    = 1'b0;
    line_err_d = 1'b0;
    cmd0_d     = c0_q;
    cmd1_d     = c1_q;
    if (rx_evt) begin
      to_cnt_d = '0;
      unique case (state_q)
        StIdle: begin
          if (is_print) begin
            c0_d    = rx_fold;
            state_d = StOne;
          end else if (!is_term) begin
            state_d = StDiscard;
          end
        end
        StOne: begin
          if (is_print) begin
            c1_d    = rx_fold;
            state_d = StTwo;
          end else if (is_term) begin
            exec1_d = 1'b1;
            state_d = StIdle;
            c0_d    = '0;
            c1_d    = '0;
          end else begin
            state_d = StDiscard;
          end
        end
        StTwo: begin
          if (is_term) begin
            exec2_d = 1'b1;
            state_d = StIdle;
            c0_d    = '0;
            c1_d    = '0;
          end else begin
            state_d = StDiscard;
          end
        end
        StDiscard: begin
          if (is_term) begin
            line_err_d = 1'b1;
            state_d    = StIdle;
            c0_d       = '0;
            c1_d       = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      if (to_cnt_q == ToLast) begin
        line_err_d = 1'b1;
        state_d    = StIdle;
        c0_d       = '0;
        c1_d       = '0;
        to_cnt_d   = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  logic [4:0] btn_new;
  logic [3:0] tgl_new;
  logic       clr_new;
  logic [3:0] req_new;
  logic       hit;

  // Command decode and output pulse generation.
  always_comb begin
    btn_new = '0;
    tgl_new = '0;
    clr_new = 1'b0;
    req_new = '0;
    if (exec1_q) begin
      case (cmd0_q)
        "C":     btn_new = 5'b00001;
        "U":     btn_new = 5'b00010;
        "D":     btn_new = 5'b00100;
        "L":     btn_new = 5'b01000;
        "R":     btn_new = 5'b10000;
        default: btn_new = '0;
      endcase
    end
    if (exec2_q) begin
      if (cmd0_q == "T") begin
        case (cmd1_q)
          "0":     tgl_new = 4'b0001;
          "1":     tgl_new = 4'b0010;
          "2":     tgl_new = 4'b0100;
          "3":     tgl_new = 4'b1000;
          "X":     clr_new = 1'b1;
          default: tgl_new = '0;
        endcase
      end else if (cmd0_q == "?") begin
        case (cmd1_q)
          "W":     req_new = 4'b0001;
          "S":     req_new = 4'b0010;
          "T":     req_new = 4'b0100;
          "H":     req_new = 4'b1000;
          default: req_new = '0;
        endcase
      end
    end
    hit   = (|btn_new) | (|tgl_new) | clr_new | (|req_new);
    tgl_d = tgl_new;
    clr_d = clr_new;
    req_d = req_new;
    ok_d  = hit;
    err_d = line_err_q | ((exec1_q | exec2_q) & ~hit);

    btn_d     = btn_q;
    btn_cnt_d = btn_cnt_q;
    // A new button replaces any active one with no gap; other commands leave it alone.
    if (|btn_new) begin
      btn_d     = btn_new;
      btn_cnt_d = BtnLast;
    end else if (|btn_q) begin
      if (btn_cnt_q == '0) begin
        btn_d = '0;
      end else begin
        btn_cnt_d = btn_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q    <= StIdle;
      c0_q       <= '0;
      c1_q       <= '0;
      to_cnt_q   <= '0;
      exec1_q    <= 1'b0;
      exec2_q    <= 1'b0;
      line_err_q <= 1'b0;
      cmd0_q     <= '0;
      cmd1_q     <= '0;
      btn_q      <= '0;
      btn_cnt_q  <= '0;
      tgl_q      <= '0;
      clr_q      <= 1'b0;
      req_q      <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      c0_q       <= c0_d;
      c1_q       <= c1_d;
      to_cnt_q   <= to_cnt_d;
      exec1_q    <= exec1_d;
      exec2_q    <= exec2_d;
      line_err_q <= line_err_d;
      cmd0_q     <= cmd0_d;
      cmd1_q     <= cmd1_d;
      btn_q      <= btn_d;
      btn_cnt_q  <= btn_cnt_d;
      tgl_q      <= tgl_d;
      clr_q      <= clr_d;
      req_q      <= req_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
    end
  end

  assign oBtnC        = btn_q[0];
  assign oBtnU        = btn_q[1];
  assign oBtnD        = btn_q[2];
  assign oBtnL        = btn_q[3];
  assign oBtnR        = btn_q[4];
  assign oTglSw0      = tgl_q[0];
  assign oTglSw1      = tgl_q[1];
  assign oTglSw2      = tgl_q[2];
  assign oTglSw3      = tgl_q[3];
  assign oClrSwTgl    = clr_q;
  assign oReqWatchRpt = req_q[0];
  assign oReqSr04Rpt  = req_q[1];
  assign oReqTempRpt  = req_q[2];
  assign oReqHumRpt   = req_q[3];
  assign oCmdOk       = ok_q;
  assign oCmdErr      = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: expected per-cycle output vectors are queued
// by the stimulus and compared by an independent negedge monitor.
module tb_uart_cmd_decoder;

  localparam logic [15:0] BtnC  = 16'h8000;
  localparam logic [15:0] BtnU  = 16'h4000;
  localparam logic [15:0] BtnD  = 16'h2000;
  localparam logic [15:0] BtnL  = 16'h1000;
  localparam logic [15:0] BtnR  = 16'h0800;
  localparam logic [15:0] Tgl2  = 16'h0200;
  localparam logic [15:0] Clr   = 16'h0040;
  localparam logic [15:0] Hum   = 16'h0020;
  localparam logic [15:0] Sr04  = 16'h0008;
  localparam logic [15:0] Watch = 16'h0004;
  localparam logic [15:0] Ok    = 16'h0002;
  localparam logic [15:0] Err   = 16'h0001;
  localparam logic [15:0] BtnMask = 16'hF800;
  localparam logic [7:0]  Cr = 8'h0D;
  localparam logic [7:0]  Lf = 8'h0A;

  logic       iClk;
  logic       iRstn;
  logic [7:0] iRxData;
  logic       iRxValid;
  logic oBtnC, oBtnU, oBtnD, oBtnL, oBtnR;
  logic oTglSw0, oTglSw1, oTglSw2, oTglSw3, oClrSwTgl;
  logic oReqWatchRpt, oReqSr04Rpt, oReqTempRpt, oReqHumRpt, oCmdOk, oCmdErr;
  logic [15:0] vec;

  uart_cmd_decoder #(
    .P_BTN_PULSE_CYC(4),
    .P_TIMEOUT_CYC  (50)
  ) dut (
    .iClk        (iClk),
    .iRstn       (iRstn),
    .iRxData     (iRxData),
    .iRxValid    (iRxValid),
    .oBtnC       (oBtnC),
    .oBtnU       (oBtnU),
    .oBtnD       (oBtnD),
    .oBtnL       (oBtnL),
    .oBtnR       (oBtnR),
    .oTglSw0     (oTglSw0),
    .oTglSw1     (oTglSw1),
    .oTglSw2     (oTglSw2),
    .oTglSw3     (oTglSw3),
    .oClrSwTgl   (oClrSwTgl),
    .oReqWatchRpt(oReqWatchRpt),
    .oReqSr04Rpt (oReqSr04Rpt),
    .oReqTempRpt (oReqTempRpt),
    .oReqHumRpt  (oReqHumRpt),
    .oCmdOk      (oCmdOk),
    .oCmdErr     (oCmdErr)
  );

  assign vec = {oBtnC, oBtnU, oBtnD, oBtnL, oBtnR, oTglSw3, oTglSw2, oTglSw1, oTglSw0,
                oClrSwTgl, oReqHumRpt, oReqTempRpt, oReqSr04Rpt, oReqWatchRpt, oCmdOk, oCmdErr};

  typedef struct {
    int          cyc;
    logic [15:0] vec;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks;
  int   errors;
  int   cyc;

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  // Monitor: every cycle must match the queued vector for that cycle, or be all-zero.
  always @(negedge iClk) begin
    if (iRstn) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        mon_e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_cycle %0d: got nothing want %h", mon_e.cyc, mon_e.vec);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        mon_e = q.pop_front();
        checks++;
        if (vec !== mon_e.vec) begin
          errors++;
          $display("FAIL out_cycle %0d: got %h want %h", cyc, vec, mon_e.vec);
        end
      end else if (vec !== 16'h0000) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cycle %0d: got %h want 0000", cyc, vec);
      end
    end
  end

  task automatic push_exp(input int c, input logic [15:0] v);
    exp_t e;
    int   idx;
    bit   found;
    idx   = q.size();
    found = 1'b0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == c) begin
        q[i].vec = q[i].vec | v;
        found    = 1'b1;
      end else if (q[i].cyc > c) begin
        idx = i;
      end
    end
    if (!found) begin
      e.cyc = c;
      e.vec = v;
      q.insert(idx, e);
    end
  endtask

  // A new button cancels the remainder of any earlier button pulse.
  task automatic exp_btn(input logic [15:0] b, input int start);
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].cyc >= start) q[i].vec = q[i].vec & ~BtnMask;
    end
    for (int i = 0; i < 4; i++) push_exp(start + i, b);
    push_exp(start, Ok);
  endtask

  task automatic send_byte(input logic [7:0] b);
    iRxData  = b;
    iRxValid = 1'b1;
    @(posedge iClk);
    #1;
    iRxValid = 1'b0;
    iRxData  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic check_now(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  int n;

  initial begin
    checks   = 0;
    errors   = 0;
    iRstn    = 1'b0;
    iRxData  = 8'h00;
    iRxValid = 1'b0;
    #2;
    check_now("reset_outputs", vec, 16'h0000);
    #20;
    iRstn = 1'b1;
    idle(2);

    // Buttons, including lowercase folding
    send_str("C"); send_byte(Cr); n = cyc; exp_btn(BtnC, n + 1);
    idle(8);
    send_str("u"); send_byte(Lf); n = cyc; exp_btn(BtnU, n + 1);
    idle(8);

    // Two-character commands; trailing LF of CR LF is an empty line
    send_str("T2"); send_byte(Cr); n = cyc; push_exp(n + 1, Tgl2 | Ok);
    send_byte(Lf);
    idle(5);
    send_str("TX"); send_byte(Cr); n = cyc; push_exp(n + 1, Clr | Ok);
    idle(5);
    send_str("?H"); send_byte(Cr); n = cyc; push_exp(n + 1, Hum | Ok);
    idle(5);
    send_str("? s"); send_byte(Cr); n = cyc; push_exp(n + 1, Sr04 | Ok);
    idle(5);

    // Rejected lines
    send_str("Q"); send_byte(Cr); n = cyc; push_exp(n + 1, Err);
    idle(5);
    send_str("T5"); send_byte(Cr); n = cyc; push_exp(n + 1, Err);
    idle(5);
    send_str("TXY"); send_byte(Cr); n = cyc; push_exp(n + 1, Err);
    idle(5);
    send_str("C"); send_byte(8'h07); send_byte(Cr); n = cyc; push_exp(n + 1, Err);
    idle(5);

    // Button preemption: R starts two cycles after L
    send_str("L"); send_byte(Cr); n = cyc; exp_btn(BtnL, n + 1);
    send_str("R"); send_byte(Cr); n = cyc; exp_btn(BtnR, n + 1);
    idle(10);

    // Timeout after 50 idle cycles mid-line, then recovery
    send_str("?"); n = cyc; push_exp(n + 51, Err);
    idle(60);
    send_str("?W"); send_byte(Cr); n = cyc; push_exp(n + 1, Watch | Ok);
    idle(5);
    // Byte on the expiry edge keeps the line alive
    send_str("?");
    idle(49);
    send_str("W"); send_byte(Cr); n = cyc; push_exp(n + 1, Watch | Ok);
    idle(60);

    // Reset during a button pulse
    send_str("D"); send_byte(Cr); n = cyc; exp_btn(BtnD, n + 1);
    idle(2);
    check_now("btnD_before_reset", vec, BtnD);
    q.delete();
    iRstn = 1'b0;
    #1;
    check_now("reset_mid_pulse", vec, 16'h0000);
    repeat (2) @(posedge iClk);
    #3;
    iRstn = 1'b1;
    idle(2);
    // Reset after a partial line; a lone CR afterwards must do nothing
    send_str("T");
    iRstn = 1'b0;
    #1;
    check_now("reset_mid_line", vec, 16'h0000);
    repeat (2) @(posedge iClk);
    #3;
    iRstn = 1'b1;
    idle(2);
    send_byte(Cr);
    idle(10);
    check_now("idle_after_reset_cr", vec, 16'h0000);

    for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge iClk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
